// File: rtl/fetch_predict_unit.sv
// fetch_predict_unit
// Instruction fetch front end. It issues one icache request at a time and
// pre-decodes each returned word. It predicts the next PC: JAL is always
// taken, and conditional branches use a table of 2-bit saturating counters
// that execute trains. Fetched words are buffered in a small FIFO that decode
// drains with a valid/ready handshake.
//
// Ports:
//   clk_i, rst          clock, asynchronous active-high reset
//   ic_req_o/ic_addr_o  fetch request and address to the icache
//   ic_data_ok_i/_i     icache response strobe and instruction word
//   redirect_i/_pc_i    flush the front end and restart at a new PC
//   train_*_i           resolved conditional branch outcome for the counters
//   fq_*                fetch queue head towards decode (valid/ready)
module fetch_predict_unit #(
  parameter int              XLEN      = 32,
  parameter int              BHT_DEPTH = 64,
  parameter int              FQ_DEPTH  = 4,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h8000_0000)
) (
  input  logic            clk_i,
  input  logic            rst,
  output logic            ic_req_o,
  output logic [XLEN-1:0] ic_addr_o,
  input  logic            ic_data_ok_i,
  input  logic [31:0]     ic_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            train_valid_i,
  input  logic [XLEN-1:0] train_pc_i,
  input  logic            train_taken_i,
  output logic            fq_valid_o,
  input  logic            fq_ready_i,
  output logic [31:0]     fq_instr_o,
  output logic [XLEN-1:0] fq_pc_o,
  output logic            fq_pred_taken_o,
  output logic [XLEN-1:0] fq_pred_pc_o
);

  localparam int BHT_IW = $clog2(BHT_DEPTH);
  localparam int FQ_PW  = $clog2(FQ_DEPTH);
  localparam logic [FQ_PW:0] FQ_FULL = (FQ_PW+1)'(FQ_DEPTH);
  localparam logic [FQ_PW:0] CNT_ONE = (FQ_PW+1)'(1);

  typedef enum logic {ST_FETCH, ST_DROP} state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_restartPc;
  logic [FQ_PW-1:0]  r_head;
  logic [FQ_PW-1:0]  r_tail;
  logic [FQ_PW:0]    r_count;
  logic [31:0]       r_qInstr  [FQ_DEPTH];
  logic [XLEN-1:0]   r_qPc     [FQ_DEPTH];
  logic [XLEN-1:0]   r_qPredPc [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] r_qTaken;
  logic [1:0]        r_bht     [BHT_DEPTH];

  logic              w_fetchReq;
  logic              w_push;
  logic              w_pop;
  logic [XLEN-1:0]   w_bImm;
  logic [XLEN-1:0]   w_jImm;
  logic [BHT_IW-1:0] w_predIdx;
  logic [BHT_IW-1:0] w_trainIdx;
  logic              w_predTaken;
  logic [XLEN-1:0]   w_target;
  logic [XLEN-1:0]   w_nextPc;
  logic              w_unused;

  // A new fetch is only issued when the queue has room, so a response can
  // always be pushed. While draining an abandoned request the old address
  // stays on the bus until the icache answers.
  assign w_fetchReq = (r_state == ST_FETCH) && (r_count != FQ_FULL);
  assign ic_req_o   = !rst && (w_fetchReq || (r_state == ST_DROP));
  assign ic_addr_o  = r_pc;

  assign w_push = w_fetchReq && ic_data_ok_i && !redirect_i;
  assign w_pop  = fq_valid_o && fq_ready_i && !redirect_i;

  assign w_bImm = {{(XLEN-13){ic_data_i[31]}}, ic_data_i[31], ic_data_i[7],
                   ic_data_i[30:25], ic_data_i[11:8], 1'b0};
  assign w_jImm = {{(XLEN-21){ic_data_i[31]}}, ic_data_i[31], ic_data_i[19:12],
                   ic_data_i[20], ic_data_i[30:21], 1'b0};

  assign w_predIdx  = r_pc[BHT_IW+1:2];
  assign w_trainIdx = train_pc_i[BHT_IW+1:2];
  assign w_unused   = &{1'b0, train_pc_i[XLEN-1:BHT_IW+2], train_pc_i[1:0]};

  // Pre-decode: the counter is read before any same-cycle training update.
  always_comb begin
    w_predTaken = 1'b0;
    w_target    = r_pc + XLEN'(4);
    case (ic_data_i[6:0])
      7'b1100011: begin
        w_predTaken = r_bht[w_predIdx][1];
        w_target    = r_pc + w_bImm;
      end
      7'b1101111: begin
        w_predTaken = 1'b1;
        w_target    = r_pc + w_jImm;
      end
      default: ;
    endcase
  end

  assign w_nextPc = w_predTaken ? w_target : r_pc + XLEN'(4);

  // Fetch state: FETCH normally, DROP while waiting out a request that a
  // redirect made stale. The restart PC is kept apart from the bus address.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_restartPc <= RESET_PC;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (redirect_i) begin
            if (w_fetchReq && !ic_data_ok_i) begin
              r_state     <= ST_DROP;
              r_restartPc <= redirect_pc_i;
            end else begin
              r_pc <= redirect_pc_i;
            end
          end else if (w_push) begin
            r_pc <= w_nextPc;
          end
        end
        ST_DROP: begin
          if (ic_data_ok_i) begin
            r_state <= ST_FETCH;
            r_pc    <= redirect_i ? redirect_pc_i : r_restartPc;
          end else if (redirect_i) begin
            r_restartPc <= redirect_pc_i;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // Queue bookkeeping; a redirect empties it and voids any same-cycle pop.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
    end
  end

  // Queue payload storage; contents are only visible while count is nonzero.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_qInstr[r_tail]  <= ic_data_i;
      r_qPc[r_tail]     <= r_pc;
      r_qPredPc[r_tail] <= w_nextPc;
      r_qTaken[r_tail]  <= w_predTaken;
    end
  end

  assign fq_valid_o      = (r_count != '0);
  assign fq_instr_o      = fq_valid_o ? r_qInstr[r_head]  : '0;
  assign fq_pc_o         = fq_valid_o ? r_qPc[r_head]     : '0;
  assign fq_pred_pc_o    = fq_valid_o ? r_qPredPc[r_head] : '0;
  assign fq_pred_taken_o = fq_valid_o ? r_qTaken[r_head]  : 1'b0;

  // Branch history counters, weakly not-taken out of reset.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
    end else if (train_valid_i) begin
      if (train_taken_i && (r_bht[w_trainIdx] != 2'b11))
        r_bht[w_trainIdx] <= r_bht[w_trainIdx] + 2'b01;
      else if (!train_taken_i && (r_bht[w_trainIdx] != 2'b00))
        r_bht[w_trainIdx] <= r_bht[w_trainIdx] - 2'b01;
    end
  end

endmodule
